// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution, multi-cycle divider, EX/MEM register.
// In: ID_EX_* operands/control, hazard_stall. Out: EX_MEM_*, ex_busy, redirect.
module ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hazard_stall,
  input  logic        ID_EX_enable_out,
  input  logic [31:0] ID_EX_PC,
  input  logic [31:0] ID_EX_Rs1Data,
  input  logic [31:0] ID_EX_Rs2Data,
  input  logic [31:0] ID_EX_Imm,
  input  logic [4:0]  ID_EX_Rd,
  input  logic [4:0]  ID_EX_ALUOp,
  input  logic        ID_EX_ALUSrc,
  input  logic        ID_EX_Branch,
  input  logic        ID_EX_Jump,
  input  logic        ID_EX_JalrSel,
  input  logic [2:0]  ID_EX_BrFunct3,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_MemWrite,
  input  logic        ID_EX_MemToReg,
  input  logic        ID_EX_RegWrite,
  output logic [31:0] EX_MEM_PC,
  output logic [31:0] EX_MEM_ALUResult,
  output logic [31:0] EX_MEM_WriteData,
  output logic [4:0]  EX_MEM_Rd,
  output logic        EX_MEM_MemRead,
  output logic        EX_MEM_MemWrite,
  output logic        EX_MEM_MemToReg,
  output logic        EX_MEM_RegWrite,
  output logic        EX_MEM_enable_out,
  output logic        ex_busy,
  output logic        branch_taken,
  output logic [31:0] branch_target
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0] op_a, op_b, pc_4;
  logic [31:0] alu_res;
  logic [4:0]  shamt;
  logic        m_sa, m_sb;
  logic [63:0] m_a, m_b, m_p;
  logic        cond;
  logic        valid_issue;
  logic        is_div;
  logic        div_issue;

  assign op_a  = ID_EX_Rs1Data;
  assign op_b  = ID_EX_ALUSrc ? ID_EX_Imm : ID_EX_Rs2Data;
  assign pc_4  = ID_EX_PC + 32'd4;
  assign shamt = op_b[4:0];

  // One 64-bit multiplier; operand signedness picks MULH/MULHSU/MULHU.
  assign m_sa = (ID_EX_ALUOp == 5'd13) | (ID_EX_ALUOp == 5'd14);
  assign m_sb = (ID_EX_ALUOp == 5'd13);
  assign m_a  = {{32{m_sa & op_a[31]}}, op_a};
  assign m_b  = {{32{m_sb & op_b[31]}}, op_b};
  assign m_p  = m_a * m_b;

  always_comb begin
    alu_res = '0;
    case (ID_EX_ALUOp)
      5'd0:  alu_res = op_a + op_b;
      5'd1:  alu_res = op_a - op_b;
      5'd2:  alu_res = op_a << shamt;
      5'd3:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      5'd4:  alu_res = {31'd0, op_a < op_b};
      5'd5:  alu_res = op_a ^ op_b;
      5'd6:  alu_res = op_a >> shamt;
      5'd7:  alu_res = $signed(op_a) >>> shamt;
      5'd8:  alu_res = op_a | op_b;
      5'd9:  alu_res = op_a & op_b;
      5'd10: alu_res = op_b;
      5'd11: alu_res = ID_EX_PC + op_b;
      5'd12: alu_res = m_p[31:0];
      5'd13: alu_res = m_p[63:32];
      5'd14: alu_res = m_p[63:32];
      5'd15: alu_res = m_p[63:32];
      default: alu_res = '0;
    endcase
    if (ID_EX_Jump)
      alu_res = pc_4;
  end

  always_comb begin
    cond = 1'b0;
    case (ID_EX_BrFunct3)
      3'b000: cond = ID_EX_Rs1Data == ID_EX_Rs2Data;
      3'b001: cond = ID_EX_Rs1Data != ID_EX_Rs2Data;
      3'b100: cond = $signed(ID_EX_Rs1Data) < $signed(ID_EX_Rs2Data);
      3'b101: cond = $signed(ID_EX_Rs1Data) >= $signed(ID_EX_Rs2Data);
      3'b110: cond = ID_EX_Rs1Data < ID_EX_Rs2Data;
      3'b111: cond = ID_EX_Rs1Data >= ID_EX_Rs2Data;
      default: cond = 1'b0;
    endcase
  end

  assign valid_issue = ID_EX_enable_out & ~hazard_stall & (state == IDLE);
  assign is_div      = ID_EX_ALUOp[4:2] == 3'b100;
  assign div_issue   = valid_issue & is_div;
  assign ex_busy     = div_issue | (state == RUN);

  assign branch_taken  = valid_issue &
                         (ID_EX_Jump | (ID_EX_Branch & cond));
  assign branch_target = ID_EX_JalrSel ?
                         ((op_a + ID_EX_Imm) & ~32'd1) :
                         (ID_EX_PC + ID_EX_Imm);

  // Divider: operands latched as magnitudes, sign fixed up at writeback.
  logic [31:0] div_q, div_d, div_r;
  logic [4:0]  div_cnt;
  logic        div_sq, div_sr, div_zero, div_rem;
  logic [4:0]  div_rd;
  logic [31:0] div_pc, div_wd;
  logic        div_mr, div_mw, div_m2r, div_rw;

  logic        d_sgn, d_na, d_nb;
  logic [31:0] d_abs_a, d_abs_b;
  logic [32:0] r_sh, diff;
  logic [31:0] quot, remd, div_res;

  assign d_sgn   = ~ID_EX_ALUOp[0];
  assign d_na    = d_sgn & op_a[31];
  assign d_nb    = d_sgn & op_b[31];
  assign d_abs_a = d_na ? 32'd0 - op_a : op_a;
  assign d_abs_b = d_nb ? 32'd0 - op_b : op_b;

  assign r_sh = {div_r, div_q[31]};
  assign diff = r_sh - {1'b0, div_d};

  assign quot    = div_zero ? 32'hFFFF_FFFF :
                   (div_sq ? 32'd0 - div_q : div_q);
  assign remd    = div_sr ? 32'd0 - div_r : div_r;
  assign div_res = div_rem ? remd : quot;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (div_issue) state_nx = RUN;
      RUN:  if (div_cnt == 5'd31) state_nx = DONE;
      DONE: if (!hazard_stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      div_d    <= '0;
      div_r    <= '0;
      div_cnt  <= '0;
      div_sq   <= 1'b0;
      div_sr   <= 1'b0;
      div_zero <= 1'b0;
      div_rem  <= 1'b0;
      div_rd   <= '0;
      div_pc   <= '0;
      div_wd   <= '0;
      div_mr   <= 1'b0;
      div_mw   <= 1'b0;
      div_m2r  <= 1'b0;
      div_rw   <= 1'b0;
    end else if (state == IDLE) begin
      if (div_issue) begin
        div_q    <= d_abs_a;
        div_d    <= d_abs_b;
        div_r    <= '0;
        div_cnt  <= '0;
        div_sq   <= d_na ^ d_nb;
        div_sr   <= d_na;
        div_zero <= (op_b == 32'd0) & ~ID_EX_ALUOp[1];
        div_rem  <= ID_EX_ALUOp[1];
        div_rd   <= ID_EX_Rd;
        div_pc   <= ID_EX_PC;
        div_wd   <= ID_EX_Rs2Data;
        div_mr   <= ID_EX_MemRead;
        div_mw   <= ID_EX_MemWrite;
        div_m2r  <= ID_EX_MemToReg;
        div_rw   <= ID_EX_RegWrite;
      end
    end else if (state == RUN) begin
      div_cnt <= div_cnt + 5'd1;
      if (!diff[32]) begin
        div_r <= diff[31:0];
        div_q <= {div_q[30:0], 1'b1};
      end else begin
        div_r <= r_sh[31:0];
        div_q <= {div_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      EX_MEM_PC         <= '0;
      EX_MEM_ALUResult  <= '0;
      EX_MEM_WriteData  <= '0;
      EX_MEM_Rd         <= '0;
      EX_MEM_MemRead    <= 1'b0;
      EX_MEM_MemWrite   <= 1'b0;
      EX_MEM_MemToReg   <= 1'b0;
      EX_MEM_RegWrite   <= 1'b0;
      EX_MEM_enable_out <= 1'b0;
    end else if (hazard_stall) begin
      EX_MEM_PC         <= '0;
      EX_MEM_ALUResult  <= '0;
      EX_MEM_WriteData  <= '0;
      EX_MEM_Rd         <= '0;
      EX_MEM_MemRead    <= 1'b0;
      EX_MEM_MemWrite   <= 1'b0;
      EX_MEM_MemToReg   <= 1'b0;
      EX_MEM_RegWrite   <= 1'b0;
      EX_MEM_enable_out <= 1'b1;
    end else if (state == DONE) begin
      EX_MEM_PC         <= div_pc;
      EX_MEM_ALUResult  <= div_res;
      EX_MEM_WriteData  <= div_wd;
      EX_MEM_Rd         <= div_rd;
      EX_MEM_MemRead    <= div_mr;
      EX_MEM_MemWrite   <= div_mw;
      EX_MEM_MemToReg   <= div_m2r;
      EX_MEM_RegWrite   <= div_rw;
      EX_MEM_enable_out <= 1'b1;
    end else if (state == RUN || div_issue) begin
      EX_MEM_enable_out <= 1'b0;
    end else if (ID_EX_enable_out) begin
      EX_MEM_PC         <= ID_EX_PC;
      EX_MEM_ALUResult  <= alu_res;
      EX_MEM_WriteData  <= ID_EX_Rs2Data;
      EX_MEM_Rd         <= ID_EX_Rd;
      EX_MEM_MemRead    <= ID_EX_MemRead;
      EX_MEM_MemWrite   <= ID_EX_MemWrite;
      EX_MEM_MemToReg   <= ID_EX_MemToReg;
      EX_MEM_RegWrite   <= ID_EX_RegWrite;
      EX_MEM_enable_out <= 1'b1;
    end else begin
      EX_MEM_enable_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table, divider sequences,
// reset abort and branch redirect, with an expected-result queue.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hazard_stall;
  logic        ID_EX_enable_out;
  logic [31:0] ID_EX_PC, ID_EX_Rs1Data, ID_EX_Rs2Data, ID_EX_Imm;
  logic [4:0]  ID_EX_Rd, ID_EX_ALUOp;
  logic        ID_EX_ALUSrc, ID_EX_Branch, ID_EX_Jump, ID_EX_JalrSel;
  logic [2:0]  ID_EX_BrFunct3;
  logic        ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg;
  logic        ID_EX_RegWrite;
  logic [31:0] EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg;
  logic        EX_MEM_RegWrite, EX_MEM_enable_out;
  logic        ex_busy, branch_taken;
  logic [31:0] branch_target;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk),
    .reset_n(reset_n),
    .hazard_stall(hazard_stall),
    .ID_EX_enable_out(ID_EX_enable_out),
    .ID_EX_PC(ID_EX_PC),
    .ID_EX_Rs1Data(ID_EX_Rs1Data),
    .ID_EX_Rs2Data(ID_EX_Rs2Data),
    .ID_EX_Imm(ID_EX_Imm),
    .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_ALUSrc(ID_EX_ALUSrc),
    .ID_EX_Branch(ID_EX_Branch),
    .ID_EX_Jump(ID_EX_Jump),
    .ID_EX_JalrSel(ID_EX_JalrSel),
    .ID_EX_BrFunct3(ID_EX_BrFunct3),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemToReg(ID_EX_MemToReg),
    .ID_EX_RegWrite(ID_EX_RegWrite),
    .EX_MEM_PC(EX_MEM_PC),
    .EX_MEM_ALUResult(EX_MEM_ALUResult),
    .EX_MEM_WriteData(EX_MEM_WriteData),
    .EX_MEM_Rd(EX_MEM_Rd),
    .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_MemToReg(EX_MEM_MemToReg),
    .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .EX_MEM_enable_out(EX_MEM_enable_out),
    .ex_busy(ex_busy),
    .branch_taken(branch_taken),
    .branch_target(branch_target)
  );

  typedef struct {
    logic [4:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic sb_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_res"}, EX_MEM_ALUResult, e.res);
      chk({nm, "_wd"}, EX_MEM_WriteData, e.wd);
      chk({nm, "_rd"}, {27'd0, EX_MEM_Rd}, {27'd0, e.rd});
    end
  endtask

  task automatic clear_in();
    hazard_stall     = 1'b0;
    ID_EX_enable_out = 1'b0;
    ID_EX_PC         = '0;
    ID_EX_Rs1Data    = '0;
    ID_EX_Rs2Data    = '0;
    ID_EX_Imm        = '0;
    ID_EX_Rd         = '0;
    ID_EX_ALUOp      = '0;
    ID_EX_ALUSrc     = 1'b0;
    ID_EX_Branch     = 1'b0;
    ID_EX_Jump       = 1'b0;
    ID_EX_JalrSel    = 1'b0;
    ID_EX_BrFunct3   = '0;
    ID_EX_MemRead    = 1'b0;
    ID_EX_MemWrite   = 1'b0;
    ID_EX_MemToReg   = 1'b0;
    ID_EX_RegWrite   = 1'b0;
  endtask

  task automatic drive(input logic [4:0] op, input logic src,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rd);
    ID_EX_enable_out = 1'b1;
    ID_EX_ALUOp      = op;
    ID_EX_ALUSrc     = src;
    ID_EX_Rs1Data    = a;
    ID_EX_Rs2Data    = b;
    ID_EX_Imm        = imm;
    ID_EX_Rd         = rd;
    ID_EX_RegWrite   = 1'b1;
  endtask

  task automatic run_div(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] req,
                         input int nstall, input string nm);
    int busy;
    int en_bad;
    int bub_bad;
    exp_t e;
    drive(op, 1'b0, a, b, 32'h0, 5'd9);
    ID_EX_PC = 32'h0000_0800;
    #1;
    busy = int'(ex_busy);
    e.res = req;
    e.wd  = b;
    e.rd  = 5'd9;
    sb.push_back(e);
    @(posedge clk); #1;
    en_bad = 0;
    for (int k = 1; k <= 32; k++) begin
      busy += int'(ex_busy);
      if (EX_MEM_enable_out !== 1'b0) en_bad++;
      if (branch_taken !== 1'b0) en_bad++;
      @(posedge clk); #1;
    end
    busy += int'(ex_busy);
    if (EX_MEM_enable_out !== 1'b0) en_bad++;
    chk({nm, "_en_low"}, en_bad, 0);
    chk({nm, "_busy33"}, busy, 33);
    bub_bad = 0;
    if (nstall > 0) begin
      hazard_stall = 1'b1;
      for (int s = 0; s < nstall; s++) begin
        @(posedge clk); #1;
        if (EX_MEM_enable_out !== 1'b1) bub_bad++;
        if (EX_MEM_RegWrite !== 1'b0) bub_bad++;
        if (EX_MEM_ALUResult !== 32'd0) bub_bad++;
        if (EX_MEM_Rd !== 5'd0) bub_bad++;
        if (ex_busy !== 1'b0) bub_bad++;
      end
      chk({nm, "_bubbles"}, bub_bad, 0);
      hazard_stall = 1'b0;
    end
    @(posedge clk); #1;
    ID_EX_enable_out = 1'b0;
    chk({nm, "_en"}, {31'd0, EX_MEM_enable_out}, 32'd1);
    chk({nm, "_rw"}, {31'd0, EX_MEM_RegWrite}, 32'd1);
    sb_check(nm);
  endtask

  initial begin
    int idle_bad;
    exp_t e;
    clear_in();
    vecs[0]  = '{5'd0,  1'b0, 32'd2, 32'd3, 32'h0, 32'd5};
    vecs[1]  = '{5'd1,  1'b0, 32'd3, 32'd5, 32'h0, 32'hFFFF_FFFE};
    vecs[2]  = '{5'd7,  1'b0, 32'h8000_0000, 32'd4, 32'h0,
                 32'hF800_0000};
    vecs[3]  = '{5'd15, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
                 32'hFFFF_FFFE};
    vecs[4]  = '{5'd2,  1'b0, 32'd3, 32'h21, 32'h0, 32'd6};
    vecs[5]  = '{5'd3,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1};
    vecs[6]  = '{5'd4,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0};
    vecs[7]  = '{5'd5,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,
                 32'h0FF0_0FF0};
    vecs[8]  = '{5'd6,  1'b0, 32'h8000_0000, 32'd4, 32'h0,
                 32'h0800_0000};
    vecs[9]  = '{5'd8,  1'b0, 32'h0F, 32'hF0, 32'h0, 32'hFF};
    vecs[10] = '{5'd9,  1'b0, 32'hFF0, 32'h0FF, 32'h0, 32'h0F0};
    vecs[11] = '{5'd10, 1'b1, 32'hDEAD, 32'h55, 32'h1234_5000,
                 32'h1234_5000};
    vecs[12] = '{5'd11, 1'b1, 32'h0, 32'h55, 32'h2000, 32'h3000};
    vecs[13] = '{5'd12, 1'b0, 32'd7, 32'd6, 32'h0, 32'd42};
    vecs[14] = '{5'd13, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'h0,
                 32'hFFFF_FFFF};
    vecs[15] = '{5'd14, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
                 32'hFFFF_FFFF};
    vecs[16] = '{5'd25, 1'b0, 32'd1, 32'd2, 32'h0, 32'd0};
    vecs[17] = '{5'd0,  1'b1, 32'd10, 32'h55, 32'hFFFF_FFFD, 32'd7};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", EX_MEM_ALUResult, 32'd0);
    chk("rst_en", {31'd0, EX_MEM_enable_out}, 32'd0);
    chk("rst_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("rst_pc", EX_MEM_PC, 32'd0);
    chk("rst_busy", {31'd0, ex_busy}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b,
            vecs[i].imm, 5'(i + 1));
      ID_EX_PC = 32'h0000_1000;
      e.res = vecs[i].exp;
      e.wd  = vecs[i].b;
      e.rd  = 5'(i + 1);
      sb.push_back(e);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_en", i), {31'd0, EX_MEM_enable_out}, 32'd1);
      chk($sformatf("vec%0d_pc", i), EX_MEM_PC, 32'h0000_1000);
      sb_check($sformatf("vec%0d", i));
    end
    clear_in();
    @(posedge clk); #1;
    chk("idle_en", {31'd0, EX_MEM_enable_out}, 32'd0);

    run_div(5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div_m7_2");
    run_div(5'd18, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem_m7_2");
    run_div(5'd17, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divu_by0");
    run_div(5'd18, 32'd5, 32'd0, 32'd5, 0, "rem_by0");
    run_div(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,
            "div_ovf");
    run_div(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "rem_ovf");
    run_div(5'd17, 32'd100, 32'd7, 32'd14, 3, "divu_stall");
    run_div(5'd19, 32'd100, 32'd7, 32'd2, 0, "remu");

    // abort a division with reset in the middle of RUN
    drive(5'd16, 1'b0, 32'd100, 32'd3, 32'h0, 5'd4);
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    clear_in();
    #1;
    chk("abort_res", EX_MEM_ALUResult, 32'd0);
    chk("abort_en", {31'd0, EX_MEM_enable_out}, 32'd0);
    chk("abort_rd", {27'd0, EX_MEM_Rd}, 32'd0);
    chk("abort_busy", {31'd0, ex_busy}, 32'd0);
    ID_EX_enable_out = 1'b1;
    ID_EX_Jump = 1'b1;
    #1;
    chk("abort_idle", {31'd0, branch_taken}, 32'd1);
    clear_in();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    drive(5'd0, 1'b0, 32'd2, 32'd3, 32'h0, 5'd7);
    e.res = 32'd5;
    e.wd  = 32'd3;
    e.rd  = 5'd7;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("post_rst_en", {31'd0, EX_MEM_enable_out}, 32'd1);
    sb_check("post_rst_add");
    clear_in();
    idle_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (EX_MEM_enable_out !== 1'b0) idle_bad++;
    end
    chk("abort_no_result", idle_bad, 0);

    // branch / jump redirect
    drive(5'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd0);
    ID_EX_RegWrite = 1'b0;
    ID_EX_PC = 32'h100;
    ID_EX_Branch = 1'b1;
    ID_EX_BrFunct3 = 3'b100;
    #1;
    chk("blt_taken", {31'd0, branch_taken}, 32'd1);
    chk("blt_target", branch_target, 32'h120);
    ID_EX_BrFunct3 = 3'b101;
    #1;
    chk("bge_taken", {31'd0, branch_taken}, 32'd0);
    ID_EX_BrFunct3 = 3'b110;
    #1;
    chk("bltu_taken", {31'd0, branch_taken}, 32'd0);
    ID_EX_BrFunct3 = 3'b100;
    hazard_stall = 1'b1;
    #1;
    chk("blt_stall", {31'd0, branch_taken}, 32'd0);
    hazard_stall = 1'b0;
    clear_in();
    drive(5'd0, 1'b0, 32'h203, 32'd0, 32'h0, 5'd1);
    ID_EX_PC = 32'h400;
    ID_EX_Jump = 1'b1;
    ID_EX_JalrSel = 1'b1;
    #1;
    chk("jalr_taken", {31'd0, branch_taken}, 32'd1);
    chk("jalr_target", branch_target, 32'h202);
    e.res = 32'h404;
    e.wd  = 32'd0;
    e.rd  = 5'd1;
    sb.push_back(e);
    @(posedge clk); #1;
    sb_check("jalr_link");
    clear_in();
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage core: takes decoded operands from the ID/EX register, computes the ALU result, resolves branches and jumps, and registers everything into the EX/MEM register consumed by the memory stage. DIV/DIVU/REM/REMU run on a 32-iteration restoring divider that stalls the front end through `ex_busy`. MUL-class ops are single-cycle combinational.

## Interface
- No parameters. The datapath is fixed at 32 bits.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- hazard_stall  in  1  global stall; inserts a bubble into EX/MEM
- ID_EX_enable_out  in  1  ID/EX holds a valid instruction
- ID_EX_PC, ID_EX_Rs1Data, ID_EX_Rs2Data, ID_EX_Imm  in  32 each  PC, operands (already forwarded), immediate
- ID_EX_Rd  in  5  destination register
- ID_EX_ALUOp  in  5  operation code (see Operation)
- ID_EX_ALUSrc  in  1  operand B select: 1 = Imm, 0 = Rs2Data
- ID_EX_Branch, ID_EX_Jump, ID_EX_JalrSel  in  1 each  conditional branch, unconditional jump, JALR target select
- ID_EX_BrFunct3  in  3  branch condition
- ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_RegWrite  in  1 each  control bits passed through
- EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData  out  32 each  registered outputs
- EX_MEM_Rd  out  5  registered output
- EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_enable_out  out  1 each  registered outputs
- ex_busy  out  1  combinational; upstream must hold ID/EX while high
- branch_taken  out  1  combinational redirect request
- branch_target  out  32  combinational redirect address

## Operation
- Operands: A = Rs1Data. B = ALUSrc ? Imm : Rs2Data. WriteData = Rs2Data. Shift amount = B[4:0].
- ALUOp encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 LUI (result B), 11 AUIPC (PC+B)
  - 12 MUL (low 32), 13 MULH, 14 MULHSU, 15 MULHU (high 32 of the 64-bit product)
  - 16 DIV, 17 DIVU, 18 REM, 19 REMU
  - 20–31 give result 0.
- Jump = 1: ALUResult = PC+4 regardless of ALUOp.
- Branch condition by BrFunct3:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU
  - Other codes are never taken.
- Redirect:
  - branch_taken = valid_issue & (Jump | (Branch & cond)).
  - valid_issue = ID_EX_enable_out & ~hazard_stall & state==IDLE.
  - branch_target = JalrSel ? (Rs1Data+Imm) & ~1 : PC+Imm.
- Divider FSM, states IDLE / RUN / DONE:
  - IDLE→RUN when valid_issue and ALUOp is 16–19. On that edge: latch |A|, |B|, sign flags, op, Rd and control bits; clear count.
  - RUN: one restoring iteration per edge. After the 32nd iteration (count==31) go to DONE, even if hazard_stall is high.
  - DONE→IDLE on the first edge with hazard_stall=0. On that edge EX_MEM loads the signed-corrected result and EX_MEM_enable_out=1.
  - DONE with hazard_stall=1: stay in DONE and keep the result.
- Divider special results, always with full latency:
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = dividend.
  - DIV of 0x80000000 by -1: quotient 0x80000000, REM 0.
  - Quotient sign = sA^sB. Remainder sign = sA.
- ex_busy = (state==IDLE & valid_issue & div op) | state==RUN. It is 0 in DONE, so upstream advances on the DONE edge.
- EX/MEM update priority, per edge:
  1. Reset
  2. hazard_stall: bubble. All data and control outputs 0, EX_MEM_enable_out=1.
  3. DONE: write the divider result.
  4. RUN or division issue: EX_MEM_enable_out=0, other outputs hold.
  5. ID_EX_enable_out: normal update, EX_MEM_enable_out=1.
  6. Otherwise EX_MEM_enable_out=0, others hold.

## Timing
- Reset: every EX_MEM_* output is 0 and the state is IDLE. reset_n asserted mid-division aborts it with no result.
- Single-cycle ops: operands present in cycle N, EX_MEM valid after edge N.
- Division with no stalls:
  - Issue edge E0, iterations E1–E32, EX_MEM written at E33 (34 edges total).
  - ex_busy is high from the issue cycle through the cycle before E32.
- branch_taken / branch_target are valid in the same cycle as the operands. They are never asserted while the divider is in RUN or DONE.

## Test plan
- Reset mid-RUN: all outputs 0 and state IDLE. A following ADD 2+3 gives EX_MEM_ALUResult=5 with enable_out=1 one edge later.
- SUB 3−5 → 0xFFFFFFFE. SRA 0x80000000 by 4 → 0xF8000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → −3. REM −7/2 → −1.
  - Both land on E33.
  - ex_busy is high for exactly 33 cycles.
  - EX_MEM_enable_out=0 during E1–E32.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000.
- hazard_stall held for 3 cycles while in DONE: three bubbles with enable_out=1 and control bits 0, then the correct quotient once the stall drops.
- Branch/jump redirect:
  - BLT −1 vs 1, PC=0x100, Imm=0x20: branch_taken=1, target 0x120.
  - JALR with Rs1=0x203, Imm=0: target 0x202, ALUResult=PC+4.
  - Same BLT with hazard_stall=1: branch_taken=0.
